// File: rtl/nf10_decoder_arbiter.sv
// Two-input AXI4-Stream packet arbiter with per-stream forwarded-packet counters.
//
// Ports:
//   axi_aclk, axi_resetn             - clock (rising edge), asynchronous active-low reset
//   s_axis_*_0, s_axis_*_1           - input streams 0 and 1 (tdata/tstrb/tuser/tvalid/tlast/tready)
//   m_axis_*                         - merged output stream
//   pkt_cnt_0, pkt_cnt_1             - packets forwarded from stream 0 / stream 1 (wrapping)
//
// A grant is issued from IDLE and held for a whole packet; the beat carrying tlast returns the
// arbiter to IDLE, so every packet is followed by one IDLE cycle. On contention the stream that
// was not served last wins.
module nf10_decoder_arbiter #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axi_aclk,
  input  logic                            axi_resetn,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
  input  logic                            s_axis_tvalid_0,
  input  logic                            s_axis_tlast_0,
  output logic                            s_axis_tready_0,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
  input  logic                            s_axis_tvalid_1,
  input  logic                            s_axis_tlast_1,
  output logic                            s_axis_tready_1,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,

  output logic [31:0]                     pkt_cnt_0,
  output logic [31:0]                     pkt_cnt_1
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e      state_q, state_d;
  logic        last_served_q, last_served_d;
  logic [31:0] pkt_cnt_0_q, pkt_cnt_0_d;
  logic [31:0] pkt_cnt_1_q, pkt_cnt_1_d;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q       <= StIdle;
      last_served_q <= 1'b1;  // stream 0 wins the first contention
      pkt_cnt_0_q   <= '0;
      pkt_cnt_1_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      pkt_cnt_0_q   <= pkt_cnt_0_d;
      pkt_cnt_1_q   <= pkt_cnt_1_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    last_served_d   = last_served_q;
    pkt_cnt_0_d     = pkt_cnt_0_q;
    pkt_cnt_1_d     = pkt_cnt_1_q;
    m_axis_tdata    = '0;
    m_axis_tstrb    = '0;
    m_axis_tuser    = '0;
    m_axis_tvalid   = 1'b0;
    m_axis_tlast    = 1'b0;
    s_axis_tready_0 = 1'b0;
    s_axis_tready_1 = 1'b0;

    case (state_q)
      StIdle: begin
        if (s_axis_tvalid_0 && s_axis_tvalid_1) begin
          state_d = last_served_q ? StGrant0 : StGrant1;
        end else if (s_axis_tvalid_0) begin
          state_d = StGrant0;
        end else if (s_axis_tvalid_1) begin
          state_d = StGrant1;
        end
      end

      StGrant0: begin
        m_axis_tdata    = s_axis_tdata_0;
        m_axis_tstrb    = s_axis_tstrb_0;
        m_axis_tuser    = s_axis_tuser_0;
        m_axis_tvalid   = s_axis_tvalid_0;
        m_axis_tlast    = s_axis_tlast_0;
        s_axis_tready_0 = m_axis_tready;
        if (s_axis_tvalid_0 && s_axis_tlast_0 && m_axis_tready) begin
          state_d       = StIdle;
          last_served_d = 1'b0;
          pkt_cnt_0_d   = pkt_cnt_0_q + 32'd1;
        end
      end

      StGrant1: begin
        m_axis_tdata    = s_axis_tdata_1;
        m_axis_tstrb    = s_axis_tstrb_1;
        m_axis_tuser    = s_axis_tuser_1;
        m_axis_tvalid   = s_axis_tvalid_1;
        m_axis_tlast    = s_axis_tlast_1;
        s_axis_tready_1 = m_axis_tready;
        if (s_axis_tvalid_1 && s_axis_tlast_1 && m_axis_tready) begin
          state_d       = StIdle;
          last_served_d = 1'b1;
          pkt_cnt_1_d   = pkt_cnt_1_q + 32'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign pkt_cnt_0 = pkt_cnt_0_q;
  assign pkt_cnt_1 = pkt_cnt_1_q;

endmodule

// File: doc/nf10_decoder_arbiter.md
NF10_DECODER_ARBITER -- requirements
Module: nf10_decoder_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256: tdata width of all ports.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128: tuser width of all ports.
REQ-003 SHALL have port axi_aclk  in  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port axi_resetn  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have ports s_axis_tdata_N  in  C_AXIS_DATA_WIDTH, for N = 0, 1: input stream N data.
REQ-006 SHALL have ports s_axis_tstrb_N  in  C_AXIS_DATA_WIDTH/8, for N = 0, 1: input stream N byte strobes.
REQ-007 SHALL have ports s_axis_tuser_N  in  C_AXIS_TUSER_WIDTH, for N = 0, 1: input stream N sideband.
REQ-008 SHALL have ports s_axis_tvalid_N / s_axis_tlast_N  in  1, and s_axis_tready_N  out  1, for N = 0, 1: input stream N handshake.
REQ-009 SHALL have ports m_axis_tdata / m_axis_tstrb / m_axis_tuser  out, same widths as the inputs: merged output stream.
REQ-010 SHALL have ports m_axis_tvalid / m_axis_tlast  out  1, and m_axis_tready  in  1: merged output handshake.
REQ-011 SHALL have ports pkt_cnt_0 / pkt_cnt_1  out  32: packets forwarded from stream 0 and stream 1.

Function
REQ-012 SHALL implement a three-state FSM:
- IDLE: no grant.
- GRANT0: stream 0 owns the output.
- GRANT1: stream 1 owns the output.
REQ-013 SHALL leave IDLE for GRANTn when s_axis_tvalid_n is high; the grant takes effect in the next cycle (1-cycle arbitration latency).
REQ-014 SHALL, when both s_axis_tvalid inputs are high in IDLE, grant the stream other than last_served (1-bit register).
REQ-015 SHALL, in GRANTn, drive m_axis tdata, tstrb, tuser, tvalid and tlast combinationally from stream n, and drive s_axis_tready_n = m_axis_tready.
REQ-016 SHALL hold the non-granted stream's s_axis_tready low in GRANTn, and hold both s_axis_tready low in IDLE.
REQ-017 SHALL, in IDLE, drive m_axis_tvalid = 0, m_axis_tlast = 0, and m_axis tdata, tstrb and tuser all zero.
REQ-018 SHALL keep the grant for the whole packet; arbitration is packet-granular, with no interleaving of beats from the two streams.
REQ-019 SHALL, on a cycle with m_axis_tvalid & m_axis_tready & m_axis_tlast in GRANTn:
- go to IDLE next cycle;
- set last_served = n;
- increment pkt_cnt_n by 1.
REQ-020 SHALL let pkt_cnt_n wrap from 0xFFFFFFFF to 0 with no saturation or flag.
REQ-021 SHALL NOT, in GRANTn, change state when stream n deasserts tvalid mid-packet; it waits for stream n.
REQ-022 SHALL NOT change state or counters in GRANTn when m_axis_tready is low (backpressure); the selected stream's data stays on the output.
REQ-023 SHALL end a single-beat packet (tlast on the first beat) in the same way, so every packet is followed by one IDLE cycle.
REQ-024 SHALL ignore tlast on the non-granted stream.

Reset
REQ-025 SHALL, while axi_resetn = 0 and independent of the clock:
- state = IDLE;
- last_served = 1 (stream 0 wins first contention);
- pkt_cnt_0 = pkt_cnt_1 = 0;
- all s_axis_tready = 0;
- m_axis_tvalid = 0, m_axis_tlast = 0, m_axis data/strb/user = 0.
REQ-026 SHALL, on reset asserted mid-packet, abandon the packet with no count update; after release, arbitration resumes from IDLE.

Verification
REQ-027 Bench SHALL cover: both tvalid high from the cycle after reset release, 3-beat packets on each stream, m_axis_tready = 1 -> stream 0 packet beats on output cycles 2-4, IDLE on cycle 5, stream 1 packet on cycles 6-8; pkt_cnt_0 = pkt_cnt_1 = 1.
REQ-028 Bench SHALL cover: only stream 1 active, 2 packets -> both forwarded with one IDLE cycle between; s_axis_tready_0 = 0 throughout; pkt_cnt_1 = 2.
REQ-029 Bench SHALL cover: m_axis_tready low for 5 cycles mid-packet -> output beat held stable; s_axis_tready of the granted stream low; no state or counter change.
REQ-030 Bench SHALL cover: pkt_cnt_0 preloaded via force to 0xFFFFFFFF, one stream 0 packet -> pkt_cnt_0 = 0.
REQ-031 Bench SHALL cover: axi_resetn pulsed low between clock edges during beat 2 of stream 0 -> outputs cleared immediately; after release with both streams valid, stream 0 is granted first.
REQ-032 Bench SHALL cover: single-beat packets with both streams continuously valid -> strict alternation 0,1,0,1 with one IDLE cycle between packets.
